// File: rtl/imem_boot_ctrl_pkg.sv
// Shared definitions for the instruction-memory boot loader: memory geometry,
// the NOP fed to the core while it is held, FSM state codes and state decode helpers.
package imem_boot_ctrl_pkg;

    localparam int          IMEM_AW   = 10;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR0 = 3'd1;
    localparam logic [2:0] ST_HDR1 = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_CSUM = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;
    localparam logic [2:0] ST_ERR  = 3'd6;

    // States in which the stream is being consumed (byte_ready and timeout active).
    function automatic logic is_loading(input logic [2:0] st);
        return (st == ST_HDR0) || (st == ST_HDR1) || (st == ST_DATA) || (st == ST_CSUM);
    endfunction

    // States in which the core is held and fed NOPs.
    function automatic logic is_holding(input logic [2:0] st);
        return is_loading(st) || (st == ST_ERR);
    endfunction

endpackage

// File: rtl/imem_boot_ctrl_byte2word_pack.sv
// Collects little-endian bytes into 32-bit words. The completed word and its
// valid flag are presented in the same cycle the fourth byte is offered, so the
// parent can register the word on the accepting edge.
module imem_boot_ctrl_byte2word_pack (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        clr_i,
    input  logic        byte_en_i,
    input  logic [7:0]  byte_data_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  lane_r;
    logic [23:0] shift_r;

    // Lane counter and shift register holding the first three bytes of a word.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lane_r  <= 2'd0;
            shift_r <= 24'h00_0000;
        end else if (clr_i) begin
            lane_r  <= 2'd0;
            shift_r <= 24'h00_0000;
        end else if (byte_en_i) begin
            lane_r  <= lane_r + 2'd1;
            shift_r <= {byte_data_i, shift_r[23:8]};
        end else begin
            lane_r  <= lane_r;
            shift_r <= shift_r;
        end
    end

    assign word_valid_o = byte_en_i && (lane_r == 2'd3);
    assign word_o       = {byte_data_i, shift_r};

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot-time loader for the instruction memory. Receives a byte stream
// (16-bit word count, little-endian words, XOR checksum word), writes the words
// into IMEM and holds the core on NOPs until the program is verified.
module imem_boot_ctrl
    import imem_boot_ctrl_pkg::*;
#(
    parameter int          AW      = IMEM_AW,
    parameter int          TIMEOUT = 100000,
    parameter logic [31:0] NOP     = NOP_INSTR
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          boot_req_i,
    input  logic          byte_valid_i,
    input  logic [7:0]    byte_data_i,
    output logic          byte_ready_o,
    input  logic [31:0]   pc_i,
    output logic [31:0]   instr_o,
    output logic          cpu_hold_o,
    output logic [31:0]   mem_rdaddr_o,
    input  logic [31:0]   mem_rddata_i,
    output logic          mem_wr_en_o,
    output logic [AW-1:0] mem_wr_addr_o,
    output logic [31:0]   mem_wr_data_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);

    localparam int DEPTH = 2 ** AW;
    localparam int TW    = $clog2(TIMEOUT + 1);

    logic [2:0]    state_r;
    logic [2:0]    state_nxt_s;
    logic          byte_acc_s;
    logic          enter_hdr0_s;
    logic          pack_en_s;
    logic          word_valid_s;
    logic [31:0]   word_s;
    logic [15:0]   cnt_s;
    logic          last_word_s;
    logic          to_hit_s;
    logic [AW:0]   idx_next_s;

    logic [7:0]    hdr_lo_r;
    logic [15:0]   cnt_r;
    logic [AW:0]   word_idx_r;
    logic [31:0]   csum_r;
    logic [TW-1:0] to_cnt_r;

    logic          byte_ready_r;
    logic          hold_r;
    logic          done_r;
    logic          err_r;
    logic          pass_r;
    logic          mem_wr_en_r;
    logic [AW-1:0] mem_wr_addr_r;
    logic [31:0]   mem_wr_data_r;

    assign byte_acc_s   = byte_valid_i && byte_ready_r;
    assign enter_hdr0_s = ((state_r == ST_IDLE) || (state_r == ST_ERR)) && boot_req_i;
    assign pack_en_s    = byte_acc_s && ((state_r == ST_DATA) || (state_r == ST_CSUM));
    assign cnt_s        = {byte_data_i, hdr_lo_r};
    assign idx_next_s   = word_idx_r + {{AW{1'b0}}, 1'b1};
    assign last_word_s  = (16'(idx_next_s) == cnt_r);
    assign to_hit_s     = is_loading(state_r) && !byte_acc_s
                          && (to_cnt_r == TW'(TIMEOUT - 1));

    imem_boot_ctrl_byte2word_pack u_pack (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .clr_i        (enter_hdr0_s),
        .byte_en_i    (pack_en_s),
        .byte_data_i  (byte_data_i),
        .word_valid_o (word_valid_s),
        .word_o       (word_s)
    );

    // Next-state decision for the load sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (boot_req_i) state_nxt_s = ST_HDR0;
                else            state_nxt_s = ST_IDLE;
            end
            ST_HDR0: begin
                if (to_hit_s)        state_nxt_s = ST_ERR;
                else if (byte_acc_s) state_nxt_s = ST_HDR1;
                else                 state_nxt_s = ST_HDR0;
            end
            ST_HDR1: begin
                if (to_hit_s)                             state_nxt_s = ST_ERR;
                else if (!byte_acc_s)                     state_nxt_s = ST_HDR1;
                else if (cnt_s == 16'h0000)               state_nxt_s = ST_CSUM;
                else if (32'(cnt_s) > 32'(DEPTH))         state_nxt_s = ST_ERR;
                else                                      state_nxt_s = ST_DATA;
            end
            ST_DATA: begin
                if (to_hit_s)                         state_nxt_s = ST_ERR;
                else if (word_valid_s && last_word_s) state_nxt_s = ST_CSUM;
                else                                  state_nxt_s = ST_DATA;
            end
            ST_CSUM: begin
                if (to_hit_s)            state_nxt_s = ST_ERR;
                else if (!word_valid_s)  state_nxt_s = ST_CSUM;
                else if (word_s == csum_r) state_nxt_s = ST_DONE;
                else                     state_nxt_s = ST_ERR;
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            ST_ERR: begin
                if (boot_req_i) state_nxt_s = ST_HDR0;
                else            state_nxt_s = ST_ERR;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_r <= ST_IDLE;
        else          state_r <= state_nxt_s;
    end

    // Header capture, word index, running checksum and inter-byte timeout counter.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hdr_lo_r   <= 8'h00;
            cnt_r      <= 16'h0000;
            word_idx_r <= '0;
            csum_r     <= 32'h0000_0000;
            to_cnt_r   <= '0;
        end else if (enter_hdr0_s) begin
            hdr_lo_r   <= 8'h00;
            cnt_r      <= 16'h0000;
            word_idx_r <= '0;
            csum_r     <= 32'h0000_0000;
            to_cnt_r   <= '0;
        end else begin
            if (is_loading(state_r) && !byte_acc_s) to_cnt_r <= to_cnt_r + {{(TW-1){1'b0}}, 1'b1};
            else                                    to_cnt_r <= '0;
            if ((state_r == ST_HDR0) && byte_acc_s) hdr_lo_r <= byte_data_i;
            else                                    hdr_lo_r <= hdr_lo_r;
            if ((state_r == ST_HDR1) && byte_acc_s) cnt_r <= cnt_s;
            else                                    cnt_r <= cnt_r;
            if ((state_r == ST_DATA) && word_valid_s) begin
                csum_r     <= csum_r ^ word_s;
                word_idx_r <= idx_next_s;
            end else begin
                csum_r     <= csum_r;
                word_idx_r <= word_idx_r;
            end
        end
    end

    // IMEM write port: one strobe in the cycle after a data word completes.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_wr_en_r   <= 1'b0;
            mem_wr_addr_r <= '0;
            mem_wr_data_r <= 32'h0000_0000;
        end else if ((state_r == ST_DATA) && word_valid_s) begin
            mem_wr_en_r   <= 1'b1;
            mem_wr_addr_r <= word_idx_r[AW-1:0];
            mem_wr_data_r <= word_s;
        end else begin
            mem_wr_en_r   <= 1'b0;
            mem_wr_addr_r <= mem_wr_addr_r;
            mem_wr_data_r <= mem_wr_data_r;
        end
    end

    // Status flags registered from the next state so they line up with state_r.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            byte_ready_r <= 1'b0;
            hold_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            pass_r       <= 1'b1;
        end else begin
            byte_ready_r <= is_loading(state_nxt_s);
            hold_r       <= is_holding(state_nxt_s);
            done_r       <= (state_nxt_s == ST_DONE);
            err_r        <= (state_nxt_s == ST_ERR);
            pass_r       <= (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_DONE);
        end
    end

    assign byte_ready_o  = byte_ready_r;
    assign cpu_hold_o    = hold_r;
    assign busy_o        = hold_r;
    assign done_o        = done_r;
    assign err_o         = err_r;
    assign mem_wr_en_o   = mem_wr_en_r;
    assign mem_wr_addr_o = mem_wr_addr_r;
    assign mem_wr_data_o = mem_wr_data_r;

    // The fetch path is a pure pass-through once the core is released.
    assign instr_o      = hold_r ? NOP : mem_rddata_i;
    assign mem_rdaddr_o = pass_r ? pc_i : 32'h0000_0000;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Randomized self-checking bench for imem_boot_ctrl with a behavioural IMEM and
// a stream-level reference model (expected writes, checksum outcome, readback).
module tb_imem_boot_ctrl;

    localparam int AW = 10;
    localparam int TO = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          boot_req = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'h00;
    logic          byte_ready;
    logic [31:0]   pc = 32'h0;
    logic [31:0]   instr;
    logic          cpu_hold;
    logic [31:0]   mem_rdaddr;
    logic [31:0]   mem_rddata;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [31:0]   mem_wr_data;
    logic          busy, done, err;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;

    logic [31:0] imem [0:1023];
    logic        tb_we = 1'b0;
    logic [9:0]  tb_wa = 10'd0;
    logic [31:0] tb_wd = 32'h0;

    logic [9:0]  exp_addr_q [$];
    logic [31:0] exp_data_q [$];
    logic [31:0] prog [0:15];

    always #5 clk = ~clk;

    imem_boot_ctrl #(.AW(AW), .TIMEOUT(TO), .NOP(NOP)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .boot_req_i(boot_req),
        .byte_valid_i(byte_valid), .byte_data_i(byte_data), .byte_ready_o(byte_ready),
        .pc_i(pc), .instr_o(instr), .cpu_hold_o(cpu_hold),
        .mem_rdaddr_o(mem_rdaddr), .mem_rddata_i(mem_rddata),
        .mem_wr_en_o(mem_wr_en), .mem_wr_addr_o(mem_wr_addr), .mem_wr_data_o(mem_wr_data),
        .busy_o(busy), .done_o(done), .err_o(err)
    );

    // Behavioural IMEM: synchronous write, combinational read.
    always @(posedge clk) begin
        if (mem_wr_en) imem[mem_wr_addr] <= mem_wr_data;
        else if (tb_we) imem[tb_wa] <= tb_wd;
    end
    assign mem_rddata = imem[mem_rdaddr[11:2]];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Write and done-pulse monitor against the expected-write queue.
    always @(negedge clk) begin
        if (mem_wr_en) begin
            if (exp_addr_q.size() == 0) begin
                check_eq("wr_unexpected", {22'd0, mem_wr_addr}, 32'hFFFF_FFFF);
            end else begin
                check_eq("wr_addr", {22'd0, mem_wr_addr}, {22'd0, exp_addr_q.pop_front()});
                check_eq("wr_data", mem_wr_data, exp_data_q.pop_front());
            end
        end
        if (done) begin
            done_cnt++;
            check_eq("done_hold", {31'd0, cpu_hold}, 32'd0);
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit got = 1'b0;
        if (gap > 0) begin
            byte_valid = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (byte_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check_eq("ready_timeout", 32'd0, 32'd1);
        else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_boot();
        @(posedge clk);
        #1 boot_req = 1'b1;
        @(posedge clk);
        #1 boot_req = 1'b0;
        check_eq("boot_err_clr", {31'd0, err}, 32'd0);
        check_eq("boot_busy", {31'd0, busy}, 32'd1);
    endtask

    // Full load of prog[0..n-1] with the given checksum word.
    task automatic load(input int n, input logic [31:0] csum, input int maxgap, input bit ok);
        int d0;
        int k;
        d0 = done_cnt;
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(10'(i));
            exp_data_q.push_back(prog[i]);
        end
        start_boot();
        send_byte(8'(n), 0);
        send_byte(8'(n >> 8), 0);
        for (int i = 0; i < n; i++)
            for (int b = 0; b < 4; b++)
                send_byte(prog[i][8*b +: 8], $urandom_range(maxgap, 0));
        for (int b = 0; b < 4; b++)
            send_byte(csum[8*b +: 8], $urandom_range(maxgap, 0));
        byte_valid = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("done_pulses", 32'(done_cnt - d0), ok ? 32'd1 : 32'd0);
        check_eq("err_flag", {31'd0, err}, ok ? 32'd0 : 32'd1);
        check_eq("hold_after", {31'd0, cpu_hold}, ok ? 32'd0 : 32'd1);
        check_eq("writes_pending", 32'(exp_addr_q.size()), 32'd0);
        if (!ok) check_eq("nop_in_err", instr, NOP);
        if (ok && n > 0) begin
            k = $urandom_range(n - 1, 0);
            pc = 32'(k * 4);
            #1;
            check_eq("rd_addr", mem_rdaddr, pc);
            check_eq("readback", instr, prog[k]);
        end
    endtask

    function automatic logic [31:0] xor_of(input int n);
        logic [31:0] x = 32'h0;
        for (int i = 0; i < n; i++) x ^= prog[i];
        return x;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] cs;
        int n;
        bit ok;

        // 1: reset pass-through
        tb_we = 1'b1; tb_wa = 10'd2; tb_wd = 32'hDEAD_BEEF;
        pc = 32'h8;
        repeat (2) @(posedge clk);
        #1 tb_we = 1'b0;
        @(negedge clk);
        check_eq("rst_rdaddr", mem_rdaddr, 32'h8);
        check_eq("rst_instr", instr, 32'hDEAD_BEEF);
        check_eq("rst_hold", {31'd0, cpu_hold}, 32'd0);
        check_eq("rst_flags", {28'd0, busy, done, err, byte_ready}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("idle_ready", {31'd0, byte_ready}, 32'd0);

        // 2: good two-word program
        prog[0] = 32'h0050_0093; prog[1] = 32'h0010_0113;
        load(2, 32'h0040_0180, 2, 1'b1);

        // 3: same stream, wrong checksum; then a good reload clears err
        load(2, 32'h0000_0000, 1, 1'b0);
        repeat (3) @(negedge clk);
        check_eq("err_sticky", {31'd0, err}, 32'd1);
        load(2, 32'h0040_0180, 0, 1'b1);

        // 4: empty program, then oversize count
        load(0, 32'h0000_0000, 1, 1'b1);
        start_boot();
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        byte_valid = 1'b0;
        @(negedge clk);
        check_eq("oversize_err", {31'd0, err}, 32'd1);
        check_eq("oversize_ready", {31'd0, byte_ready}, 32'd0);

        // 5: stall mid-word -> timeout, no partial write
        start_boot();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        for (int b = 0; b < 3; b++) send_byte(8'hA0 + 8'(b), 0);
        byte_valid = 1'b0;
        repeat (TO + 4) @(negedge clk);
        check_eq("timeout_err", {31'd0, err}, 32'd1);
        check_eq("timeout_busy", {31'd0, busy}, 32'd1);
        check_eq("timeout_nowr", 32'(exp_addr_q.size()), 32'd0);

        // 6a: reset in the middle of DATA
        prog[0] = $urandom; prog[1] = $urandom; prog[2] = $urandom;
        exp_addr_q.push_back(10'd0); exp_data_q.push_back(prog[0]);
        start_boot();
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        for (int b = 0; b < 4; b++) send_byte(prog[0][8*b +: 8], 1);
        send_byte(prog[1][7:0], 0);
        byte_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_ready", {31'd0, byte_ready}, 32'd0);
        check_eq("abort_hold", {31'd0, cpu_hold}, 32'd0);
        rst_n = 1'b1;
        pc = 32'h0;
        @(negedge clk);
        check_eq("abort_keep", instr, prog[0]);
        check_eq("abort_wr", 32'(exp_addr_q.size()), 32'd0);

        // 6b: byte held valid while ready is low before the load starts
        prog[0] = $urandom; prog[1] = $urandom;
        byte_valid = 1'b1; byte_data = 8'h02;
        repeat (3) @(posedge clk);
        load(2, xor_of(2), 2, 1'b1);

        // randomized programs
        for (int it = 0; it < 8; it++) begin
            n  = $urandom_range(6, 1);
            ok = 1'($urandom_range(1, 0));
            for (int i = 0; i < n; i++) prog[i] = $urandom;
            cs = xor_of(n);
            if (!ok) cs ^= (32'h1 << $urandom_range(31, 0));
            load(n, cs, 3, ok);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
